sub_bytes_pipe: RTL and testbench

SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

---
 rtl/sub_bytes_pipe.sv | 127 ++++++++++++
 tb/tb_sub_bytes_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_pipe.sv
// rtl/sub_bytes_pipe.sv - LANES-wide AES SubBytes over a LATENCY-stage valid/ready pipeline.
// Define INV_SBOX_EN to add the inverse S-box selected per beat by in_inv.
module sub_bytes_pipe #(
  parameter int LANES   = 16,
  parameter int LATENCY = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [8*LANES-1:0]                 in_data,
  input  logic                               in_inv,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [8*LANES-1:0]                 out_data,
  output logic [$clog2(LATENCY+1)-1:0]       in_flight
);

  localparam int W  = 8 * LANES;
  localparam int CW = $clog2(LATENCY + 1);

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} >> (8 - n);
    return w[7:0];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = gf_inv(b);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

`ifdef INV_SBOX_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    return gf_inv(t);
  endfunction
`endif

  logic [W-1:0] sub_data;

  always_comb begin
    sub_data = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef INV_SBOX_EN
      sub_data[8*i +: 8] = in_inv ? inv_sbox(in_data[8*i +: 8]) : fwd_sbox(in_data[8*i +: 8]);
`else
      sub_data[8*i +: 8] = fwd_sbox(in_data[8*i +: 8]);
`endif
    end
  end

  logic [LATENCY:1]        v_q, v_d;
  logic [LATENCY:1]        inv_q, inv_d;
  logic [LATENCY:1][W-1:0] data_q, data_d;
  logic                    adv;

  assign adv = !v_q[LATENCY] || out_ready;

  always_comb begin
    v_d    = v_q;
    inv_d  = inv_q;
    data_d = data_q;
    if (adv) begin
      v_d[1]    = in_valid;
      inv_d[1]  = in_inv;
      data_d[1] = sub_data;
      for (int k = 2; k <= LATENCY; k++) begin
        v_d[k]    = v_q[k-1];
        inv_d[k]  = inv_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      inv_q  <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      inv_q  <= inv_d;
      data_q <= data_d;
    end
  end

  logic [CW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int k = 1; k <= LATENCY; k++) cnt = cnt + CW'(v_q[k]);
  end

  assign in_ready  = adv;
  assign out_valid = v_q[LATENCY];
  assign out_data  = data_q[LATENCY];
  assign in_flight = cnt;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb/tb_sub_bytes_pipe.sv - self-checking bench for sub_bytes_pipe (honours INV_SBOX_EN).
// S-box tables are generated by the log/antilog walk and inverted by table lookup.
module tb_sub_bytes_pipe;

  localparam int LANES = 4;
  localparam int LAT   = 3;
  localparam int W     = 8 * LANES;
  localparam int CW    = $clog2(LAT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_inv;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] in_flight;

  sub_bytes_pipe #(.LANES(LANES), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cycles = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];
  logic [W-1:0] exp_q [$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      fwd_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endtask

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    logic use_inv;
`ifdef INV_SBOX_EN
    use_inv = inv;
`else
    use_inv = 1'b0 & inv;
`endif
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = use_inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  // Scoreboard: every accepted beat must leave exactly once, in order, with substituted lanes
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      chk("in_flight", 32'(in_flight), 32'(exp_q.size()));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: got beat %h expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(exp_word(in_data, in_inv));
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic inv);
    int n;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    stall_cycles += n - 1;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] d;
    build_tables();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_flight", 32'(in_flight), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    chk("model_fwd_00", 32'(fwd_tab[8'h00]), 32'h63);
    chk("model_fwd_53", 32'(fwd_tab[8'h53]), 32'hed);
    chk("model_fwd_ff", 32'(fwd_tab[8'hff]), 32'h16);
    chk("model_inv_63", 32'(inv_tab[8'h63]), 32'h00);
    chk("model_inv_ed", 32'(inv_tab[8'hed]), 32'h53);
    chk("model_inv_16", 32'(inv_tab[8'h16]), 32'hff);

    // FIPS-197 example column
    send({8'hbe, 8'he3, 8'h3d, 8'h19}, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("fips_latency", 32'(lat), 32'(LAT));
    chk("fips_data", out_data, 32'hae1127d4);
    @(posedge clk);
    #1;
    chk("fips_in_flight", 32'(in_flight), 32'd0);

    // All byte values back-to-back, alternating direction
    stall_cycles = 0;
    for (int i = 0; i < 256; i++) begin
      d = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
      send(d, i[0]);
    end
    in_valid = 1'b0;
    chk("stream_stalls", 32'(stall_cycles), 32'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalls for 10 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    d = 32'h10203040;
    in_data = d;
    for (int c = 0; c < 10; c++) begin
      logic acc;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        d = d + 32'h01010101;
        in_data = d;
      end
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_in_flight", 32'(in_flight), 32'(LAT));
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send(d, 1'b0);
    in_valid = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_in_flight_end", 32'(in_flight), 32'd0);

    // Reset with a full pipeline discards everything
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send(32'h0a0b0c00 + 32'(i), 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_in_flight", 32'(in_flight), 32'(LAT));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_flight", 32'(in_flight), 32'd0);
    out_ready = 1'b1;
    send(32'h00000000, 1'b0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_data", out_data, 32'h63636363);
    @(posedge clk);
    #1;

    // in_inv=1 on byte 63
    send(32'h63636363, 1'b1);
    in_valid = 1'b0;
    wait_out(lat);
`ifdef INV_SBOX_EN
    chk("inv_63", out_data, 32'h00000000);
`else
    chk("inv_63", out_data, 32'hfbfbfbfb);
`endif
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
